// File: rtl/seq_ctrl_fsm.sv
// Self-sequencing FETCH/DECODE/EXECUTE/UPDATE controller.
// Latches IR fields, inserts RAM wait states, supports halt and stall.
module seq_ctrl_fsm #(
  parameter int ADDR_W   = 7,
  parameter int REG_BASE = 64,
  parameter int RAM_WAIT = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              RUN,
  input  logic [3:0]        OPCODE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic              I_FLAG,
  input  logic [3:0]        ALU_FLAGS,
  output logic              IR_EN,
  output logic              A_EN,
  output logic              B_EN,
  output logic              PDR_EN,
  output logic              PORT_EN,
  output logic              PORT_RD,
  output logic              PC_EN,
  output logic              PC_LOAD,
  output logic              ALU_EN,
  output logic              ALU_OE,
  output logic              RAM_OE,
  output logic              RDR_EN,
  output logic              RAM_CS,
  output logic [1:0]        PHASE,
  output logic              HALTED,
  output logic              ILLEGAL
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_UPDATE,
    S_HALT
  } state_e;

  typedef enum logic [1:0] {
    C_NOP,
    C_ALU,
    C_LOAD,
    C_STORE
  } cls_e;

  localparam logic [2:0] WAIT_LAST = 3'(RAM_WAIT);
  localparam logic [ADDR_W:0] RB_LO =
    (ADDR_W+1)'(REG_BASE);
  localparam logic [ADDR_W:0] RB_HI =
    (ADDR_W+1)'(REG_BASE + 3);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  cls_e              cls_q, cls_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              imm_q, imm_d;
  logic              take_q, take_d;

  cls_e              cls_dec;
  logic              take_dec;

  logic [ADDR_W:0]   addr_x;
  logic              in_regs;
  logic              below_rb;
  logic              is_port;
  logic [1:0]        reg_off;
  logic              wait_last;
  logic              exec_wait;
  logic              ld_fire;

  assign addr_x    = {1'b0, addr_q};
  assign in_regs   = (addr_x >= RB_LO) &&
                     (addr_x <= RB_HI);
  assign below_rb  = addr_x < RB_LO;
  assign is_port   = addr_x == RB_HI;
  assign reg_off   = addr_q[1:0] - RB_LO[1:0];
  assign wait_last = cnt_q == WAIT_LAST;
  assign ld_fire   = imm_q | wait_last;

  // Only RAM-touching executes (direct load, RAM store) wait.
  assign exec_wait =
    ((cls_q == C_LOAD) && in_regs && !imm_q) ||
    ((cls_q == C_STORE) && below_rb);

  // Classify the raw opcode and resolve the branch condition.
  always_comb begin
    cls_dec = C_NOP;
    unique case (1'b1)
      (OPCODE == 4'd0): cls_dec = C_LOAD;
      (OPCODE == 4'd1): cls_dec = C_STORE;
      ((OPCODE >= 4'd2) &&
       (OPCODE <= 4'd7)): cls_dec = C_ALU;
      default: cls_dec = C_NOP;
    endcase
    take_dec =
      (OPCODE == 4'd8) ||
      ((OPCODE == 4'd9)  && ALU_FLAGS[1]) ||
      ((OPCODE == 4'd10) && ALU_FLAGS[2]) ||
      ((OPCODE == 4'd11) && ALU_FLAGS[3]) ||
      ((OPCODE == 4'd12) && ALU_FLAGS[0]);
  end

  // State, wait counter and latched fields; reset is synchronous.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      cls_q   <= C_NOP;
      addr_q  <= '0;
      imm_q   <= 1'b0;
      take_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cls_q   <= cls_d;
      addr_q  <= addr_d;
      imm_q   <= imm_d;
      take_q  <= take_d;
    end
  end

  // Next state: everything holds while RUN is low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cls_d   = cls_q;
    addr_d  = addr_q;
    imm_d   = imm_q;
    take_d  = take_q;
    if (RUN) begin
      unique case (state_q)
        S_FETCH: begin
          if (wait_last) begin
            cnt_d   = '0;
            state_d = S_DECODE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        S_DECODE: begin
          cls_d   = cls_dec;
          addr_d  = ADDR;
          imm_d   = I_FLAG;
          take_d  = take_dec;
          state_d = (OPCODE == 4'd15) ?
                    S_HALT : S_EXEC;
        end
        S_EXEC: begin
          if (exec_wait && !wait_last) begin
            cnt_d = cnt_q + 3'd1;
          end else begin
            cnt_d   = '0;
            state_d = S_UPDATE;
          end
        end
        S_UPDATE: state_d = S_FETCH;
        S_HALT:   state_d = S_HALT;
        default:  state_d = S_FETCH;
      endcase
    end
  end

  // Control word: decode of state and latches, idle while stalled.
  always_comb begin
    IR_EN   = 1'b0;
    A_EN    = 1'b0;
    B_EN    = 1'b0;
    PDR_EN  = 1'b0;
    PORT_EN = 1'b0;
    PORT_RD = 1'b0;
    PC_EN   = 1'b0;
    PC_LOAD = 1'b0;
    ALU_EN  = 1'b0;
    ALU_OE  = 1'b0;
    RAM_OE  = 1'b0;
    RDR_EN  = 1'b0;
    RAM_CS  = 1'b1;
    ILLEGAL = 1'b0;
    HALTED  = state_q == S_HALT;
    PHASE   = 2'd0;
    unique case (state_q)
      S_DECODE: PHASE = 2'd1;
      S_EXEC:   PHASE = 2'd2;
      S_UPDATE: PHASE = 2'd3;
      default:  PHASE = 2'd0;
    endcase
    if (RUN) begin
      unique case (state_q)
        S_FETCH: begin
          RAM_OE = 1'b1;
          RAM_CS = 1'b0;
          IR_EN  = wait_last;
        end
        S_EXEC: begin
          unique case (cls_q)
            C_ALU: ALU_EN = 1'b1;
            C_LOAD: begin
              if (!in_regs) begin
                ILLEGAL = 1'b1;
              end else begin
                if (!imm_q) begin
                  RAM_OE = 1'b1;
                  RDR_EN = 1'b1;
                  RAM_CS = 1'b0;
                end
                unique case (reg_off)
                  2'd0: A_EN    = ld_fire;
                  2'd1: B_EN    = ld_fire;
                  2'd2: PDR_EN  = ld_fire;
                  default: PORT_EN = ld_fire;
                endcase
              end
            end
            C_STORE: begin
              if (below_rb) begin
                ALU_OE = 1'b1;
                RAM_CS = 1'b0;
              end else if (is_port) begin
                PORT_RD = 1'b1;
              end else begin
                ILLEGAL = 1'b1;
              end
            end
            default: ;
          endcase
        end
        S_UPDATE: begin
          PC_EN   = 1'b1;
          PC_LOAD = take_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_ctrl_fsm.sv
// Bench for seq_ctrl_fsm: vector table, directed corners,
// and random instruction streams against a cycle-list model.
module tb_seq_ctrl_fsm;

  localparam logic [14:0] M_IR    = 15'h4000;
  localparam logic [14:0] M_A     = 15'h2000;
  localparam logic [14:0] M_B     = 15'h1000;
  localparam logic [14:0] M_PDR   = 15'h0800;
  localparam logic [14:0] M_PORT  = 15'h0400;
  localparam logic [14:0] M_PRD   = 15'h0200;
  localparam logic [14:0] M_PCEN  = 15'h0100;
  localparam logic [14:0] M_PCLD  = 15'h0080;
  localparam logic [14:0] M_ALUEN = 15'h0040;
  localparam logic [14:0] M_ALUOE = 15'h0020;
  localparam logic [14:0] M_RAMOE = 15'h0010;
  localparam logic [14:0] M_RDR   = 15'h0008;
  localparam logic [14:0] M_CS    = 15'h0004;
  localparam logic [14:0] M_ILL   = 15'h0002;
  localparam logic [14:0] M_HLT   = 15'h0001;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [3:0] op;
  logic [6:0] addr;
  logic       imm;
  logic [3:0] flags;

  logic [11:0] s0, s2;
  logic        cs0, cs2, ill0, ill2, hlt0, hlt2;
  logic [1:0]  ph0, ph2;
  logic [14:0] w0, w2;

  assign w0 = {s0, cs0, ill0, hlt0};
  assign w2 = {s2, cs2, ill2, hlt2};

  always #5 clk = ~clk;

  seq_ctrl_fsm #(.ADDR_W(7), .REG_BASE(64), .RAM_WAIT(0)) u0 (
    .CLK(clk), .RESET(rst), .RUN(run), .OPCODE(op),
    .ADDR(addr), .I_FLAG(imm), .ALU_FLAGS(flags),
    .IR_EN(s0[11]), .A_EN(s0[10]), .B_EN(s0[9]),
    .PDR_EN(s0[8]), .PORT_EN(s0[7]), .PORT_RD(s0[6]),
    .PC_EN(s0[5]), .PC_LOAD(s0[4]), .ALU_EN(s0[3]),
    .ALU_OE(s0[2]), .RAM_OE(s0[1]), .RDR_EN(s0[0]),
    .RAM_CS(cs0), .PHASE(ph0), .HALTED(hlt0),
    .ILLEGAL(ill0)
  );

  seq_ctrl_fsm #(.ADDR_W(7), .REG_BASE(64), .RAM_WAIT(2)) u2 (
    .CLK(clk), .RESET(rst), .RUN(run), .OPCODE(op),
    .ADDR(addr), .I_FLAG(imm), .ALU_FLAGS(flags),
    .IR_EN(s2[11]), .A_EN(s2[10]), .B_EN(s2[9]),
    .PDR_EN(s2[8]), .PORT_EN(s2[7]), .PORT_RD(s2[6]),
    .PC_EN(s2[5]), .PC_LOAD(s2[4]), .ALU_EN(s2[3]),
    .ALU_OE(s2[2]), .RAM_OE(s2[1]), .RDR_EN(s2[0]),
    .RAM_CS(cs2), .PHASE(ph2), .HALTED(hlt2),
    .ILLEGAL(ill2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0]  ph;
    logic [14:0] w;
  } cyc_t;

  typedef struct {
    logic [3:0]  op;
    logic [6:0]  a;
    logic        i;
    logic [3:0]  f;
    logic [14:0] ex;
    logic        pcl;
    int          cyc;
  } vec_t;

  cyc_t exq[$];
  vec_t vt[$];

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, got, exp);
    end
  endtask

  function automatic void push(input logic [1:0] p,
                               input logic [14:0] w);
    cyc_t c;
    c.ph = p;
    c.w  = w;
    exq.push_back(c);
  endfunction

  // Expected per-cycle trace of one instruction, from the rules.
  task automatic build(input logic [3:0] o,
                       input logic [6:0] a,
                       input logic i,
                       input logic [3:0] f,
                       input int rw);
    logic [14:0] tgt;
    logic        tk;
    bit          inr;
    inr = (a >= 7'd64) && (a <= 7'd67);
    tgt = M_A >> (a - 7'd64);
    for (int k = 0; k <= rw; k++)
      push(2'd0, M_RAMOE | ((k == rw) ? M_IR : 15'h0));
    push(2'd1, M_CS);
    if (o == 4'd15) begin
      for (int k = 0; k < 6; k++) push(2'd0, M_CS | M_HLT);
      return;
    end
    if (o == 4'd0) begin
      if (!inr) push(2'd2, M_ILL | M_CS);
      else if (i) push(2'd2, tgt | M_CS);
      else
        for (int k = 0; k <= rw; k++)
          push(2'd2, M_RAMOE | M_RDR |
                     ((k == rw) ? tgt : 15'h0));
    end else if (o == 4'd1) begin
      if (a < 7'd64)
        for (int k = 0; k <= rw; k++) push(2'd2, M_ALUOE);
      else if (a == 7'd67) push(2'd2, M_PRD | M_CS);
      else push(2'd2, M_ILL | M_CS);
    end else if (o <= 4'd7) begin
      push(2'd2, M_ALUEN | M_CS);
    end else begin
      push(2'd2, M_CS);
    end
    tk = (o == 4'd8) || (o == 4'd9 && f[1]) ||
         (o == 4'd10 && f[2]) || (o == 4'd11 && f[3]) ||
         (o == 4'd12 && f[0]);
    push(2'd3, M_CS | M_PCEN | (tk ? M_PCLD : 15'h0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'($urandom_range(1));
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic set_ins(input logic [3:0] o,
                         input logic [6:0] a,
                         input logic i,
                         input logic [3:0] f);
    op = o; addr = a; imm = i; flags = f;
  endtask

  // Step the DUT through the queued trace, stalling at random.
  task automatic run_queue(input int which, input int p_stall);
    int          guard;
    cyc_t        e;
    logic [16:0] got, exp;
    guard = 0;
    while (exq.size() > 0 && guard < 400) begin
      guard++;
      run = int'($urandom_range(99)) >= p_stall;
      @(negedge clk);
      e   = exq[0];
      got = (which == 0) ? {ph0, w0} : {ph2, w2};
      exp = run ? {e.ph, e.w}
                : {e.ph, M_CS | (e.w & M_HLT)};
      check(which == 0 ? "trace_rw0" : "trace_rw2",
            {15'b0, got}, {15'b0, exp});
      if (run) void'(exq.pop_front());
      @(posedge clk); #1;
    end
    if (exq.size() != 0) begin
      check("trace_timeout", 32'(exq.size()), 32'd0);
      exq.delete();
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          cyc;
    logic [14:0] last_ex;
    logic        pcl;
    bit          done;
    do_reset();
    set_ins(v.op, v.a, v.i, v.f);
    run = 1'b1;
    cyc = 0; last_ex = '0; pcl = 1'b0; done = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (ph2 == 2'd2) last_ex = w2;
      if (ph2 == 2'd3) begin
        pcl  = w2[7];
        done = 1;
      end
      @(posedge clk); #1;
    end
    check($sformatf("vec%0d_exec", idx),
          32'(last_ex), 32'(v.ex));
    check($sformatf("vec%0d_pcload", idx),
          32'(pcl), 32'(v.pcl));
    check($sformatf("vec%0d_cycles", idx),
          32'(cyc), 32'(v.cyc));
  endtask

  function automatic void add_vec(input logic [3:0] o,
                                  input logic [6:0] a,
                                  input logic i,
                                  input logic [3:0] f,
                                  input logic [14:0] ex,
                                  input logic pcl,
                                  input int cyc);
    vec_t v;
    v.op = o; v.a = a; v.i = i; v.f = f;
    v.ex = ex; v.pcl = pcl; v.cyc = cyc;
    vt.push_back(v);
  endfunction

  task automatic stream(input int which, input int n);
    logic [3:0] o;
    logic [6:0] a;
    logic       i;
    logic [3:0] f;
    do_reset();
    for (int k = 0; k < n; k++) begin
      o = 4'($urandom_range(15));
      if (o == 4'd15 && k != n - 1) o = 4'd14;
      if ($urandom_range(1) == 1)
        a = 7'($urandom_range(70, 60));
      else
        a = 7'($urandom_range(127));
      i = 1'($urandom_range(1));
      f = 4'($urandom_range(15));
      set_ins(o, a, i, f);
      build(o, a, i, f, which);
      run_queue(which, 25);
    end
  endtask

  int cnt;
  int bad;
  int first;

  initial begin
    rst = 1'b1; run = 1'b0;
    set_ins(4'd0, 7'd0, 1'b0, 4'd0);

    add_vec(4'd0, 7'd64, 1'b1, 4'd0, M_A | M_CS, 1'b0, 6);
    add_vec(4'd0, 7'd65, 1'b0, 4'd0,
            M_B | M_RAMOE | M_RDR, 1'b0, 8);
    add_vec(4'd0, 7'd66, 1'b1, 4'd0, M_PDR | M_CS, 1'b0, 6);
    add_vec(4'd0, 7'd67, 1'b0, 4'd0,
            M_PORT | M_RAMOE | M_RDR, 1'b0, 8);
    add_vec(4'd0, 7'd10, 1'b1, 4'd0, M_ILL | M_CS, 1'b0, 6);
    add_vec(4'd0, 7'd68, 1'b0, 4'd0, M_ILL | M_CS, 1'b0, 6);
    add_vec(4'd1, 7'd10, 1'b0, 4'd0, M_ALUOE, 1'b0, 8);
    add_vec(4'd1, 7'd66, 1'b0, 4'd0, M_ILL | M_CS, 1'b0, 6);
    add_vec(4'd1, 7'd64, 1'b1, 4'd0, M_ILL | M_CS, 1'b0, 6);
    add_vec(4'd1, 7'd67, 1'b0, 4'd0, M_PRD | M_CS, 1'b0, 6);
    add_vec(4'd1, 7'd100, 1'b0, 4'd0, M_ILL | M_CS, 1'b0, 6);
    add_vec(4'd5, 7'd3, 1'b0, 4'd0, M_ALUEN | M_CS, 1'b0, 6);
    add_vec(4'd9, 7'd0, 1'b0, 4'b0010, M_CS, 1'b1, 6);
    add_vec(4'd9, 7'd0, 1'b0, 4'b0000, M_CS, 1'b0, 6);
    add_vec(4'd12, 7'd0, 1'b0, 4'b0001, M_CS, 1'b1, 6);
    add_vec(4'd10, 7'd0, 1'b0, 4'b0100, M_CS, 1'b1, 6);
    add_vec(4'd11, 7'd0, 1'b0, 4'b1000, M_CS, 1'b1, 6);
    add_vec(4'd11, 7'd0, 1'b0, 4'b0111, M_CS, 1'b0, 6);
    add_vec(4'd8, 7'd0, 1'b0, 4'b0000, M_CS, 1'b1, 6);
    add_vec(4'd13, 7'd0, 1'b0, 4'b1111, M_CS, 1'b0, 6);
    add_vec(4'd14, 7'd0, 1'b0, 4'b0010, M_CS, 1'b0, 6);

    // Reset state with RUN low: idle word, FETCH phase.
    do_reset();
    run = 1'b0;
    @(negedge clk);
    check("reset_idle_rw0", {15'b0, ph0, w0},
          {15'b0, 2'd0, M_CS});
    check("reset_idle_rw2", {15'b0, ph2, w2},
          {15'b0, 2'd0, M_CS});
    @(posedge clk); #1;

    // Back-to-back directed instructions, RAM_WAIT=0.
    do_reset();
    set_ins(4'd0, 7'd64, 1'b1, 4'd0);
    build(4'd0, 7'd64, 1'b1, 4'd0, 0);
    run_queue(0, 0);
    set_ins(4'd9, 7'd5, 1'b0, 4'b0010);
    build(4'd9, 7'd5, 1'b0, 4'b0010, 0);
    run_queue(0, 0);
    set_ins(4'd9, 7'd5, 1'b0, 4'b0000);
    build(4'd9, 7'd5, 1'b0, 4'b0000, 0);
    run_queue(0, 0);
    set_ins(4'd12, 7'd5, 1'b0, 4'b0001);
    build(4'd12, 7'd5, 1'b0, 4'b0001, 0);
    run_queue(0, 0);
    set_ins(4'd1, 7'd10, 1'b0, 4'd0);
    build(4'd1, 7'd10, 1'b0, 4'd0, 0);
    run_queue(0, 0);
    set_ins(4'd1, 7'd66, 1'b0, 4'd0);
    build(4'd1, 7'd66, 1'b0, 4'd0, 0);
    run_queue(0, 0);

    // Vector table, RAM_WAIT=2.
    for (int k = 0; k < vt.size(); k++) run_vec(vt[k], k);

    // Stall for 3 cycles mid-way through a direct load.
    do_reset();
    set_ins(4'd0, 7'd65, 1'b0, 4'd0);
    run = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    run = 1'b0;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if ({ph2, w2} !== {2'd2, M_CS}) bad++;
      @(posedge clk); #1;
    end
    check("stall_idle", 32'(bad), 32'd0);
    run = 1'b1;
    cnt = 0; first = 0;
    for (int k = 0; k < 10 && ph2 != 2'd3; k++) begin
      @(negedge clk);
      if (ph2 == 2'd2) begin
        first++;
        if (w2[12]) cnt++;
      end
      @(posedge clk); #1;
    end
    check("stall_b_en_once", 32'(cnt), 32'd1);
    check("stall_exec_left", 32'(first), 32'd2);
    check("stall_reach_upd", 32'(ph2), 32'd3);
    @(posedge clk); #1;

    // Reset in the middle of a fetch wait restarts the count.
    do_reset();
    set_ins(4'd5, 7'd0, 1'b0, 4'd0);
    run = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    first = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (w2[14] && first == 0) first = k;
      @(posedge clk); #1;
    end
    check("reset_midwait_ir", 32'(first), 32'd3);

    // Halt holds for 20 cycles regardless of RUN, then reset.
    do_reset();
    set_ins(4'd15, 7'd0, 1'b0, 4'd0);
    run = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      run = 1'($urandom_range(1));
      @(negedge clk);
      if ({ph2, w2} !== {2'd0, M_CS | M_HLT}) bad++;
      @(posedge clk); #1;
    end
    check("halt_hold", 32'(bad), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    run = 1'b1;
    @(negedge clk);
    check("halt_reset", {15'b0, ph2, w2},
          {15'b0, 2'd0, M_RAMOE});
    @(posedge clk); #1;

    // Random streams with random stalls.
    stream(0, 40);
    stream(2, 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
